// File: rtl/fp_div32.sv
// Iterative IEEE-754 binary32 divider: restoring radix-2, one quotient bit per cycle.
// Flush-to-zero, truncating, canonical NaN and flag layout shared with the FP multiplier.
module fp_div32 #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] div32,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  localparam logic [9:0] BIAS10 = BIAS[9:0];

  state_t      r_state, w_next;
  logic        w_accept, w_fin;

  logic        r_sign;
  logic [9:0]  r_exp;
  logic [24:0] r_rem;
  logic [23:0] r_div;
  logic [24:0] r_q;
  logic [4:0]  r_cnt;
  logic [31:0] r_res;
  logic        r_of, r_zf;
  logic        r_done;
  logic [31:0] r_div32;
  logic [3:0]  r_flags;

  // operand classification (subnormals flush to zero)
  logic [7:0]  w_ae, w_be;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf;
  logic        w_a_snan, w_b_snan, w_a_qnan, w_b_qnan;
  logic        w_sign;
  logic        w_special, w_sof, w_szf;
  logic [31:0] w_sres;

  assign w_ae     = a[30:23];
  assign w_be     = b[30:23];
  assign w_a_zero = (w_ae == 8'h00);
  assign w_b_zero = (w_be == 8'h00);
  assign w_a_inf  = (w_ae == 8'hFF) && (a[22:0] == 23'd0);
  assign w_b_inf  = (w_be == 8'hFF) && (b[22:0] == 23'd0);
  assign w_a_snan = (w_ae == 8'hFF) && (a[22:0] != 23'd0) && !a[22];
  assign w_b_snan = (w_be == 8'hFF) && (b[22:0] != 23'd0) && !b[22];
  assign w_a_qnan = (w_ae == 8'hFF) && a[22];
  assign w_b_qnan = (w_be == 8'hFF) && b[22];
  assign w_sign   = a[31] ^ b[31];

  always_comb begin
    w_special = 1'b1;
    w_sres    = 32'd0;
    w_sof     = 1'b0;
    w_szf     = 1'b0;
    if (w_a_snan)                                   w_sres = a;
    else if (w_b_snan)                              w_sres = b;
    else if (w_a_qnan)                              w_sres = a;
    else if (w_b_qnan)                              w_sres = b;
    else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero))
      w_sres = {w_sign, 8'hFF, 1'b1, 22'd1};
    else if (w_a_inf || w_b_zero) begin
      w_sres = {w_sign, 8'hFF, 23'd0};
      w_sof  = w_b_zero;
    end else if (w_a_zero || w_b_inf) begin
      w_sres = {w_sign, 31'd0};
      w_szf  = 1'b1;
    end else
      w_special = 1'b0;
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_special ? S_DONE : S_DIV;
      S_DIV:  if (r_cnt == 5'd0) w_next = S_NORM;
      S_NORM: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && start;
    w_fin    = (r_state == S_DONE);
  end

  // normalisation of the 25-bit quotient
  logic [9:0]  w_exp_n;
  logic [22:0] w_mant;
  assign w_exp_n = r_q[24] ? r_exp : r_exp - 10'd1;
  assign w_mant  = r_q[24] ? r_q[23:1] : r_q[22:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign <= 1'b0;
      r_exp  <= 10'd0;
      r_rem  <= 25'd0;
      r_div  <= 24'd0;
      r_q    <= 25'd0;
      r_cnt  <= 5'd0;
      r_res  <= 32'd0;
      r_of   <= 1'b0;
      r_zf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sign <= w_sign;
          r_exp  <= {2'b00, w_ae} - {2'b00, w_be} + BIAS10;
          r_rem  <= {2'b01, a[22:0]};
          r_div  <= {1'b1, b[22:0]};
          r_q    <= 25'd0;
          r_cnt  <= 5'd24;
          r_res  <= w_sres;
          r_of   <= w_sof;
          r_zf   <= w_szf;
        end
        S_DIV: begin
          // rem < 2*div always holds, so the shifted value fits in 25 bits
          if (r_rem >= {1'b0, r_div}) begin
            r_rem <= (r_rem - {1'b0, r_div}) << 1;
            r_q   <= {r_q[23:0], 1'b1};
          end else begin
            r_rem <= r_rem << 1;
            r_q   <= {r_q[23:0], 1'b0};
          end
          r_cnt <= r_cnt - 5'd1;
        end
        S_NORM: begin
          if ($signed(w_exp_n) >= 10'sd255) begin
            r_res <= {r_sign, 8'hFF, 23'd0};
            r_of  <= 1'b1;
            r_zf  <= 1'b0;
          end else if ($signed(w_exp_n) <= 10'sd0) begin
            r_res <= {r_sign, 31'd0};
            r_of  <= 1'b0;
            r_zf  <= 1'b1;
          end else begin
            r_res <= {r_sign, w_exp_n[7:0], w_mant};
            r_of  <= 1'b0;
            r_zf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs change only with the done pulse so they hold until the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_div32 <= 32'd0;
      r_flags <= 4'd0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_div32 <= r_res;
        r_flags <= {r_res[31], 1'b0, r_zf, r_of};
      end
    end
  end

  assign done  = r_done;
  assign div32 = r_div32;
  assign flags = r_flags;

endmodule

// File: doc/fp_div32.md
# fp_div32

Iterative single-precision (IEEE-754 binary32) divider; the companion of the combinational `FloatingPointMul32` in the multi-cycle datapath's FP unit. Computes `a / b` with a restoring radix-2 mantissa divider, one quotient bit per cycle, behind a start/busy/done handshake. Special-case classification, flush-to-zero, truncation (no rounding), canonical NaN and the 4-bit flag format all match the multiplier, so results drop into the same writeback path.

## Interface
- `BIAS`, 127, exponent bias
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  32  dividend, latched on accepted start
- `b`  in  32  divisor, latched on accepted start
- `busy`  out  1  high from the cycle after accepted start until `done`
- `done`  out  1  one-cycle pulse; `div32` and `flags` are valid from this cycle
- `div32`  out  32  quotient, held until the next `done`
- `flags`  out  4  [3]=negative, [2]=carry (always 0), [1]=zero, [0]=overflow; held with `div32`

## Operation
- States: IDLE, DIV, NORM, DONE.
- IDLE + `start`: latch operands, sign = a[31]^b[31], classify. Special case → load result, go to DONE. Otherwise rem = {1,a[22:0]}, div = {1,b[22:0]}, q = 0, cnt = 24, go to DIV.
- Classification, in priority order. Subnormal operands count as zero (flush-to-zero).
  - a sNaN, else b sNaN → that operand unchanged.
  - a qNaN, else b qNaN → that operand unchanged.
  - inf/inf or 0/0 → canonical NaN {sign, 8'hFF, 1'b1, 22'b1}.
  - inf/x, or x/0 with x≠0 → {sign, 8'hFF, 23'b0}; flags[0]=1 for x/0 only.
  - 0/x or x/inf → {sign, 31'b0}; flags[1]=1.
- DIV, per cycle: if rem ≥ div then rem ← (rem−div)<<1, q ← {q,1}; else rem ← rem<<1, q ← {q,0}. Then cnt−−. Go to NORM after the cnt=0 iteration, which gives 25 iterations.
  - q = floor(ma·2^24 / mb), q ∈ [2^23, 2^25).
  - rem is 25 bits; div is 24 bits.
- NORM: exponent is a 10-bit signed value, exp = a[30:23] − b[30:23] + BIAS.
  - If q[24]=1: mant = q[23:1]. Else: mant = q[22:0] and exp−−.
  - exp ≥ 255 → inf, flags[0]=1.
  - exp ≤ 0 → {sign, 31'b0}, flags[1]=1.
  - Otherwise → {sign, exp[7:0], mant}.
  - Register the result, go to DONE.
- DONE: `done`=1 for this cycle only; return to IDLE.
- flags[3] = registered div32[31], for every result including NaN and zero.
- flags[2] is always 0.

## Timing
- Reset values: `busy`=0, `done`=0, `div32`=0, `flags`=0; state IDLE; internal registers cleared.
- Special-case latency: accepted start at edge k → `done` high in the cycle after edge k+1.
- Normal-path latency: accepted start at edge k.
  - Edges k+1..k+25: 25 DIV iterations.
  - Edge k+26: NORM writes the result.
  - Edge k+27: DONE; `done` high in the cycle after that edge.
  - `busy` high for the whole of that interval.
- `start` while not in IDLE is ignored; the operands are not re-latched.
- `start` held high continuously: a new operation is accepted on the first IDLE cycle after DONE, so there is one idle cycle between operations.
- `a`/`b` may change freely after the accepting edge.
- `reset` mid-operation, synchronous: next state is IDLE, `busy`=0, `done` does not pulse, outputs return to 0.
- `reset` and `start` in the same cycle: reset wins, nothing is accepted.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → div32=0x40400000, flags=0000; `done` exactly 28 cycles after the start edge, `busy` high 27 cycles.
- 0x3F800000 / 0x40400000 (1.0/3.0) → 0x3EAAAAAA (truncated), flags=0000. Then 0xC1000000 / 0x40000000 → 0xC0800000, flags=1000.
- Specials, 2-cycle latency each:
  - 0x3F800000 / 0x00000000 → 0x7F800000, flags=0001.
  - 0 / 0 → 0x7FC00001, flags=0000.
  - 0x7F800001 / 1.0 → 0x7F800001.
  - 0x80000000 / 1.0 → 0x80000000, flags=1010.
- Range limits:
  - 0x7F000000 / 0x00800000 → 0x7F800000, flags=0001.
  - 0x00800000 / 0x7F000000 → 0x00000000, flags=0010.
  - Subnormal 0x00000001 / 1.0 → 0x00000000, flags=0010.
- Handshake robustness:
  - Second `start` with new operands at cycle 5 of a division is ignored; the result belongs to the first operands.
  - Assert `reset` at cycle 10 of a division → no `done` pulse, all outputs 0; the next start completes normally.
- Random normal operands: 1000 pairs against a reference model using truncating division and flush-to-zero; `div32` and `flags` must match bit-exactly.
